// File: rtl/jtkiwi_shram_pkg.sv
// Shared types for the Kiwi main/sub shared-RAM arbiter.
package jtkiwi_shram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic OWN_MAIN = 1'b0;
  localparam logic OWN_SUB  = 1'b1;

endpackage

// File: rtl/jtkiwi_shram_rr.sv
// Two-input round-robin picker: on a collision the requester that was not served last wins.
module jtkiwi_shram_rr
  import jtkiwi_shram_pkg::*;
(
  input  logic req_m,
  input  logic req_s,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_owner
);

  // grant selection
  always_comb begin
    gnt_valid = req_m | req_s;
    gnt_owner = OWN_MAIN;
    if (req_m && req_s) begin
      gnt_owner = (last == OWN_SUB) ? OWN_MAIN : OWN_SUB;
    end else if (req_s) begin
      gnt_owner = OWN_SUB;
    end else begin
      gnt_owner = OWN_MAIN;
    end
  end

endmodule

// File: rtl/jtkiwi_shram_arb.sv
// Serialises main/sub CPU accesses to the single-port shared RAM (IDLE -> ACC -> ACK),
// with round-robin on collisions and a main-side lock that blocks new sub grants.
module jtkiwi_shram_arb
  import jtkiwi_shram_pkg::*;
#(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          main_cs,
  input  logic [AW-1:0] main_addr,
  input  logic          main_we,
  input  logic [DW-1:0] main_din,
  output logic [DW-1:0] main_dout,
  output logic          main_ok,
  input  logic          sub_cs,
  input  logic [AW-1:0] sub_addr,
  input  logic          sub_we,
  input  logic [DW-1:0] sub_din,
  output logic [DW-1:0] sub_dout,
  output logic          sub_ok,
  output logic          sub_wait,
  input  logic          lock,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  state_t state_r;
  state_t state_next_s;
  logic   owner_r;
  logic   last_r;
  logic   done_m_r;
  logic   done_s_r;
  logic   elig_m_s;
  logic   elig_s_s;
  logic   gnt_valid_s;
  logic   gnt_owner_s;
  logic   grant_s;
  logic   main_ok_next_s;
  logic   sub_ok_next_s;

  // done_x keeps a still-asserted cs from being served twice
  assign elig_m_s = main_cs & ~done_m_r;
  assign elig_s_s = sub_cs & ~done_s_r & ~lock;

  jtkiwi_shram_rr u_rr (
    .req_m     (elig_m_s),
    .req_s     (elig_s_s),
    .last      (last_r),
    .gnt_valid (gnt_valid_s),
    .gnt_owner (gnt_owner_s)
  );

  // next-state and completion decode
  always_comb begin
    state_next_s   = state_r;
    main_ok_next_s = 1'b0;
    sub_ok_next_s  = 1'b0;
    grant_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) begin
          state_next_s = ACC;
          grant_s      = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACC: state_next_s = ACK;
      ACK: begin
        state_next_s = IDLE;
        if (owner_r == OWN_SUB) begin
          sub_ok_next_s = 1'b1;
        end else begin
          main_ok_next_s = 1'b1;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state, owner and round-robin history
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      owner_r <= OWN_MAIN;
      last_r  <= OWN_SUB;
    end else begin
      state_r <= state_next_s;
      if (grant_s) owner_r <= gnt_owner_s;
      if (main_ok_next_s) last_r <= OWN_MAIN;
      else if (sub_ok_next_s) last_r <= OWN_SUB;
    end
  end

  // RAM port: address/data latched at grant and held, write enable only during ACC
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr <= {AW{1'b0}};
      ram_din  <= {DW{1'b0}};
      ram_we   <= 1'b0;
    end else if (grant_s) begin
      if (gnt_owner_s == OWN_SUB) begin
        ram_addr <= sub_addr;
        ram_din  <= sub_din;
        ram_we   <= sub_we;
      end else begin
        ram_addr <= main_addr;
        ram_din  <= main_din;
        ram_we   <= main_we;
      end
    end else begin
      ram_we <= 1'b0;
    end
  end

  // completion pulses, read data return, done flags and sub stall
  always_ff @(posedge clk) begin
    if (rst) begin
      main_ok   <= 1'b0;
      sub_ok    <= 1'b0;
      main_dout <= {DW{1'b0}};
      sub_dout  <= {DW{1'b0}};
      done_m_r  <= 1'b0;
      done_s_r  <= 1'b0;
      sub_wait  <= 1'b0;
    end else begin
      main_ok  <= main_ok_next_s;
      sub_ok   <= sub_ok_next_s;
      if (main_ok_next_s) main_dout <= ram_dout;
      if (sub_ok_next_s) sub_dout <= ram_dout;
      done_m_r <= main_ok_next_s | (done_m_r & main_cs);
      done_s_r <= sub_ok_next_s | (done_s_r & sub_cs);
      sub_wait <= sub_cs & ~done_s_r & ~sub_ok_next_s;
    end
  end

endmodule

// File: tb/tb_jtkiwi_shram_arb.sv
// Directed self-checking bench for jtkiwi_shram_arb with a 1-cycle synchronous RAM model.
module tb_jtkiwi_shram_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        main_cs = 1'b0, main_we = 1'b0;
  logic [12:0] main_addr = 13'h0;
  logic [7:0]  main_din = 8'h0;
  logic [7:0]  main_dout;
  logic        main_ok;
  logic        sub_cs = 1'b0, sub_we = 1'b0;
  logic [12:0] sub_addr = 13'h0;
  logic [7:0]  sub_din = 8'h0;
  logic [7:0]  sub_dout;
  logic        sub_ok, sub_wait;
  logic        lock = 1'b0;
  logic [12:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout = 8'h0;
  logic [7:0]  mem [0:8191];

  int checks = 0;
  int errors = 0;

  jtkiwi_shram_arb #(.AW(13), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .main_cs(main_cs), .main_addr(main_addr), .main_we(main_we), .main_din(main_din),
    .main_dout(main_dout), .main_ok(main_ok),
    .sub_cs(sub_cs), .sub_addr(sub_addr), .sub_we(sub_we), .sub_din(sub_din),
    .sub_dout(sub_dout), .sub_ok(sub_ok), .sub_wait(sub_wait),
    .lock(lock),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // one full access: grant address after 1 edge, ok/dout 2 edges later
  task automatic expect_grant(input string tag, input logic is_sub,
                              input logic [12:0] addr, input logic [7:0] dat);
    tick;
    chk({tag, "_addr"}, {19'h0, ram_addr}, {19'h0, addr});
    tick;
    tick;
    chk({tag, "_ok"}, {31'h0, is_sub ? sub_ok : main_ok}, 32'h1);
    chk({tag, "_other_ok"}, {31'h0, is_sub ? main_ok : sub_ok}, 32'h0);
    chk({tag, "_dout"}, {24'h0, is_sub ? sub_dout : main_dout}, {24'h0, dat});
  endtask

  initial begin
    int bad;
    int found;
    for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
    mem[13'h0123] <= 8'hA5;
    mem[13'h0010] <= 8'h11;
    mem[13'h0020] <= 8'h22;
    mem[13'h0030] <= 8'h33;

    // reset state
    tick;
    tick;
    chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
    chk("rst_ram_addr", {19'h0, ram_addr}, 32'h0);
    chk("rst_oks", {30'h0, main_ok, sub_ok}, 32'h0);
    chk("rst_douts", {16'h0, main_dout, sub_dout}, 32'h0);
    chk("rst_sub_wait", {31'h0, sub_wait}, 32'h0);
    rst = 1'b0;

    // main read at 0x0123
    main_cs = 1'b1; main_addr = 13'h0123; main_we = 1'b0;
    tick;
    chk("mrd_addr", {19'h0, ram_addr}, 32'h0123);
    chk("mrd_we_acc", {31'h0, ram_we}, 32'h0);
    chk("mrd_ok_early", {31'h0, main_ok}, 32'h0);
    tick;
    chk("mrd_we_ack", {31'h0, ram_we}, 32'h0);
    chk("mrd_ok_early2", {31'h0, main_ok}, 32'h0);
    tick;
    chk("mrd_ok", {31'h0, main_ok}, 32'h1);
    chk("mrd_dout", {24'h0, main_dout}, 32'hA5);
    main_cs = 1'b0;
    tick;
    chk("mrd_ok_pulse", {31'h0, main_ok}, 32'h0);

    // sub write 0x5A to 0x1FFF
    sub_cs = 1'b1; sub_addr = 13'h1FFF; sub_we = 1'b1; sub_din = 8'h5A;
    chk("swr_wait_pre", {31'h0, sub_wait}, 32'h0);
    tick;
    chk("swr_we", {31'h0, ram_we}, 32'h1);
    chk("swr_addr", {19'h0, ram_addr}, 32'h1FFF);
    chk("swr_din", {24'h0, ram_din}, 32'h5A);
    chk("swr_wait_acc", {31'h0, sub_wait}, 32'h1);
    tick;
    chk("swr_we_once", {31'h0, ram_we}, 32'h0);
    chk("swr_wait_ack", {31'h0, sub_wait}, 32'h1);
    chk("swr_ok_early", {31'h0, sub_ok}, 32'h0);
    tick;
    chk("swr_ok", {31'h0, sub_ok}, 32'h1);
    chk("swr_wait_ok", {31'h0, sub_wait}, 32'h0);
    chk("swr_main_ok", {31'h0, main_ok}, 32'h0);
    chk("swr_mem", {24'h0, mem[13'h1FFF]}, 32'h5A);
    // cs still high after ok: must not be re-served
    sub_we = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (sub_ok !== 1'b0 || ram_we !== 1'b0 || sub_wait !== 1'b0) bad++;
    end
    chk("swr_no_reserve", bad, 0);
    sub_cs = 1'b0;
    tick;

    // collisions alternate main, sub, main, sub
    main_addr = 13'h0010; sub_addr = 13'h0020;
    main_cs = 1'b1; sub_cs = 1'b1;
    expect_grant("col1_main", 1'b0, 13'h0010, 8'h11);
    main_cs = 1'b0;
    expect_grant("col1_sub", 1'b1, 13'h0020, 8'h22);
    sub_cs = 1'b0;
    tick;
    main_cs = 1'b1; sub_cs = 1'b1;
    expect_grant("col2_main", 1'b0, 13'h0010, 8'h11);
    main_cs = 1'b0;
    expect_grant("col2_sub", 1'b1, 13'h0020, 8'h22);
    sub_cs = 1'b0;
    tick;
    // after a lone main access, sub wins the next collision
    main_cs = 1'b1;
    expect_grant("solo_main", 1'b0, 13'h0010, 8'h11);
    main_cs = 1'b0;
    tick;
    main_cs = 1'b1; sub_cs = 1'b1;
    expect_grant("col3_sub", 1'b1, 13'h0020, 8'h22);
    sub_cs = 1'b0;
    expect_grant("col3_main", 1'b0, 13'h0010, 8'h11);
    main_cs = 1'b0;
    tick;

    // lock holds off sub for 100 cycles while main is still served
    lock = 1'b1; sub_cs = 1'b1; sub_addr = 13'h0030;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (sub_wait !== 1'b1 || sub_ok !== 1'b0 || ram_addr === 13'h0030) bad++;
    end
    main_cs = 1'b1; main_we = 1'b1; main_addr = 13'h0040; main_din = 8'h77;
    expect_grant("lock_main", 1'b0, 13'h0040, 8'h00);
    main_cs = 1'b0; main_we = 1'b0;
    for (int i = 0; i < 57; i++) begin
      tick;
      if (sub_wait !== 1'b1 || sub_ok !== 1'b0 || ram_addr === 13'h0030) bad++;
    end
    chk("lock_block", bad, 0);
    chk("lock_main_mem", {24'h0, mem[13'h0040]}, 32'h77);
    lock = 1'b0;
    found = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (ram_addr === 13'h0030) begin
        found = 1;
        break;
      end
    end
    chk("unlock_grant", found, 1);
    tick;
    tick;
    chk("unlock_ok", {31'h0, sub_ok}, 32'h1);
    chk("unlock_dout", {24'h0, sub_dout}, 32'h33);
    sub_cs = 1'b0;
    tick;

    // lock rising during sub ACC: in-flight access completes, next is blocked
    sub_cs = 1'b1; sub_addr = 13'h0020;
    tick;
    chk("lacc_addr", {19'h0, ram_addr}, 32'h0020);
    lock = 1'b1;
    tick;
    tick;
    chk("lacc_ok", {31'h0, sub_ok}, 32'h1);
    chk("lacc_dout", {24'h0, sub_dout}, 32'h22);
    sub_cs = 1'b0;
    tick;
    sub_cs = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (sub_ok !== 1'b0 || sub_wait !== 1'b1) bad++;
    end
    chk("lacc_block", bad, 0);
    sub_cs = 1'b0; lock = 1'b0;
    tick;
    tick;

    // reset during ACC of a main write
    main_cs = 1'b1; main_we = 1'b1; main_addr = 13'h0050; main_din = 8'h99;
    tick;
    chk("rstacc_we", {31'h0, ram_we}, 32'h1);
    rst = 1'b1;
    tick;
    chk("rstacc_ram", {11'h0, ram_we, ram_addr, ram_din}, 32'h0);
    chk("rstacc_oks", {30'h0, main_ok, sub_ok}, 32'h0);
    chk("rstacc_douts", {15'h0, sub_wait, main_dout, sub_dout}, 32'h0);
    rst = 1'b0;
    tick;
    chk("rstacc_regrant", {18'h0, ram_we, ram_addr}, {18'h0, 1'b1, 13'h0050});
    chk("rstacc_no_ok", {31'h0, main_ok}, 32'h0);
    tick;
    tick;
    chk("rstacc_ok", {31'h0, main_ok}, 32'h1);
    chk("rstacc_dout", {24'h0, main_dout}, 32'h99);
    main_cs = 1'b0; main_we = 1'b0;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtkiwi_shram_arb.md
Name: jtkiwi_shram_arb

Overview:
- Arbiter/sequencer for the 8 kB single-port shared RAM between the Kiwi main CPU and the sound/sub CPU.
- Serialises accesses and applies round-robin priority on collisions.
- Honours the main-side lock (mshramen), which blocks the sub CPU entirely.
- Drives the sub CPU wait line (feeds the Z80 devwait dev_busy input) and returns read data to both requesters.

Parameters:
- AW, 13, address width (8 kB).
- DW, 8, data width.

Ports:
- clk  in  1  system clock; one clock domain only.
- rst  in  1  synchronous, active-high reset.
- main_cs  in  1  main CPU request, level; held until main_ok.
- main_addr  in  AW  main address; stable while main_cs is high.
- main_we  in  1  main write strobe qualifier.
- main_din  in  DW  main write data.
- main_dout  out  DW  main read data.
- main_ok  out  1  one-cycle completion pulse.
- sub_cs  in  1  sub CPU request, level.
- sub_addr  in  AW  sub address.
- sub_we  in  1  sub write qualifier.
- sub_din  in  DW  sub write data.
- sub_dout  out  DW  sub read data.
- sub_ok  out  1  one-cycle completion pulse.
- sub_wait  out  1  sub CPU stall, registered.
- lock  in  1  mshramen: main owns RAM; no new sub grants.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  DW  RAM read data; 1-cycle synchronous read.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets:
  - state=IDLE; ram_we=0; ram_addr=0; ram_din=0;
  - main_ok=sub_ok=0; main_dout=sub_dout=0; sub_wait=0;
  - done_m=done_s=0; last=SUB, so main wins the first collision.
  - An in-flight access is abandoned and no ok is issued.
- Eligibility:
  - main eligible = main_cs & ~done_m.
  - sub eligible = sub_cs & ~done_s & ~lock.
- done_x is set on ok_x and cleared on the first cycle cs_x is low. This prevents re-serving a still-asserted cs after its ok.
- FSM states: IDLE, ACC, ACK.
- IDLE:
  - If no requester is eligible, stay in IDLE.
  - If exactly one is eligible, owner = that requester.
  - If both are eligible, owner = the one that is not `last`.
  - Then go to ACC.
- ACC (one cycle):
  - ram_addr and ram_din come from the owner.
  - ram_we = owner_we, asserted for exactly this cycle.
  - Go to ACK.
- ACK (one cycle):
  - owner_dout <= ram_dout for both reads and writes.
  - owner_ok = 1 for one cycle; last <= owner.
  - Go to IDLE.
- Latency: request sampled at IDLE edge n; ram_we/addr valid during n+1; ok and dout during n+2; next grant at n+3 at the earliest.
- dout holds its value until that requester's next ACK.
- The non-owner's ok and dout are untouched.
- ram_addr and ram_din hold their last values outside ACC; ram_we=0 outside ACC.
- sub_wait = sub_cs & ~done_s & ~sub_ok_next, registered. It is high from the cycle after sub_cs rises until the cycle sub_ok pulses, and low otherwise.
- Boundary cases:
  - lock rising during a sub ACC/ACK: the in-flight access completes; only new grants are blocked.
  - lock high: sub_wait stays high indefinitely while sub_cs is high.
  - cs dropping before ok: the access still completes, ok still pulses; a write is still committed.
  - Owner requests again directly after ok without dropping cs: not served until cs goes low, then high again.
  - Back-to-back collisions alternate main, sub, main, ...

Decomposition:
- Package jtkiwi_shram_pkg holds:
  - state encoding constants: IDLE=2'd0, ACC=2'd1, ACK=2'd2;
  - owner constants: OWN_MAIN=1'b0, OWN_SUB=1'b1.
- One sub-module, jtkiwi_shram_rr: two-input round-robin picker.
  - Inputs: req_m, req_s, last.
  - Outputs: gnt_valid, gnt_owner; purely combinational.
- The FSM, data capture and done/wait logic stay in the top module.

Test Plan:
- Reset, then main read at 0x0123 with RAM holding 0xA5: ram_addr=0x0123 at n+1, main_ok=1 and main_dout=0xA5 at n+2, ram_we never high.
- Sub write 0x5A to 0x1FFF: ram_we=1 for exactly one cycle with ram_addr=0x1FFF and ram_din=0x5A; sub_ok at n+2; sub_wait high n+1..n+1, low at n+2.
- main_cs and sub_cs rise in the same cycle, both held with re-requests three times: grants go main, sub, main, sub, ...; never the same requester twice while the other waits.
- lock=1 with sub_cs held 100 cycles: no sub grant and sub_wait=1 throughout; main accesses still served. Drop lock: sub served within 3 cycles.
- lock rises during sub ACC: the sub access completes with sub_ok; the next sub request is blocked.
- rst during ACC of a main write: no main_ok; all outputs return to 0 next cycle; main_cs still high after reset is re-served from IDLE, since done_m is cleared by reset.
